btc_dec_comp_code_sink: RTL and testbench
=========================================

Name: btc_dec_comp_code_sink

Overview:
- Output-side counterpart of the component code source.
- Collects hard decisions and extrinsic metrics from pDEC_NUM parallel component decoders and turns them back into line words for the extrinsic/HD memory writer.
- Col mode: a one-register pass-through of the co-indexed decoder outputs.
- Row mode: a per-decoder deserializer (pDEC_NUM serial samples -> one line) with a one-line-per-cycle output arbiter.

Parameters:
pEXTR_W, 5, extrinsic metric width (signed)
pDEC_NUM, 8, number of component decoders = line width; power of 2, >=2

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous reset, active-low
iclkena  in  1  clock enable; all state frozen when low
irow_mode  in  1  1 = row mode (deserialize), 0 = col mode
ival  in  pDEC_NUM x 1  per-decoder sample valid
istrb  in  pDEC_NUM x strb_t  per-decoder strobes (sof/sop/eop/eof)
ihd  in  pDEC_NUM x 1  per-decoder hard decision
iLextr  in  pDEC_NUM x pEXTR_W  per-decoder extrinsic metric
oval  out  1  line word valid
ovec  out  pDEC_NUM  per-slot valid mask of the line word
ostrb  out  strb_t  line strobes
ohd  out  pDEC_NUM x 1  line hard decisions
oLextr  out  pDEC_NUM x pEXTR_W  line extrinsics
oerr  out  1  sticky overflow flag (hold register overwritten)

Behaviour:
- Reset (ireset=0, async): all outputs 0; all counters 0; all pending flags 0; line and hold buffers 0. oerr clears only by reset.
- Every register update is qualified by iclkena.
- Col mode, 1-cycle latency: sample at edge k -> outputs valid after edge k.
  - oval = |ival; ovec = ival.
  - ohd[i]/oLextr[i] = ihd[i]/iLextr[i] where ival[i]=1, else 0.
  - ostrb = istrb of the lowest valid index.
- Row mode, per decoder g:
  - Slot counter cnt[g] in 0..pDEC_NUM-1.
  - On ival[g]: write {ihd,iLextr} into line[g][cnt[g]], set fill bit, then cnt[g]++.
  - istrb[g].sop with ival forces the write into slot 0 and sets cnt to 1.
  - Strobe fields of all samples in the line are OR-accumulated.
- Line completes on a write to slot pDEC_NUM-1, or on a sample with istrb[g].eop, whichever comes first (early eop = short line).
  - On completion, on the same edge: line, fill mask and accumulated strobe are copied to hold[g]; pending[g] is set; cnt[g], fill bits and strobe accumulator are cleared.
  - Unfilled slots hold hd=0, Lextr=0, and their ovec bit is 0.
- Arbiter, each cycle:
  - The lowest-index pending[g] is emitted to the output registers (oval=1, ovec=fill mask) and its pending flag is cleared.
  - Latency: last sample at edge k -> oval after edge k+1 when there is no contention.
  - At most one line per cycle; the others wait in hold.
- Collision: completion on g while pending[g]=1 and g not granted this cycle -> hold[g] overwritten with the new line, oerr<=1 (old line lost).
  - Completion on g in the same cycle g is granted -> old line emitted, new line loaded, no error.
- Mode change: any irow_mode change, detected against its registered value, clears all cnt, fill, pending and accumulators on the next edge. Outputs in that cycle follow col/row rules for the new mode with empty state; oerr is kept.
- ival low for a decoder simply stalls its deserializer; no timeout.

Decomposition:
- strb_t, extr_t and pDEC_NUM-related log2 constants stay in the shared btc_dec_types header/package; no new typedefs there.
- Natural sub-module: btc_dec_comp_code_deser, one per decoder. It holds cnt, line, fill mask, strobe accumulator, hold register and pending flag, with a grant input and a collision output.
- Top level: mode-change detect, col-mode path, priority arbiter, output mux/registers, oerr.

Test Plan:
All tests run with pDEC_NUM=4, pEXTR_W=5.
1. Col mode: ival=4'b1011, iLextr={3,-5,7,15}, ihd={1,0,1,1} -> next cycle oval=1, ovec=1011, oLextr slot2=0, other slots equal the inputs, ostrb = istrb[0].
2. Row mode, decoder 1 only: 4 consecutive valid samples Lextr 1,2,3,4, first with sop -> 2 cycles after the 4th sample: oval=1, ovec=1111, oLextr={1,2,3,4} in slot order, ostrb.sop=1; oval low otherwise.
3. Row mode, decoders 0 and 2 complete on the same edge -> decoder 0's line in cycle n, decoder 2's line in cycle n+1, oerr stays 0.
4. Row mode, decoder 3 completes twice while blocked (decoder 0 kept pending every cycle via continuous completions) -> oerr=1, only the second line of decoder 3 is emitted.
5. Row mode, sop then eop on the 2nd sample (Lextr -7, 6) -> ovec=0011, oLextr={-7,6,0,0}, ostrb.sop=ostrb.eop=1.
6. Reset asserted mid-line (2 of 4 samples in), then a full 4-sample line -> all outputs 0 during reset, and the following line emits exactly the 4 new samples with ovec=1111.

Source files
------------

// File: rtl/btc_dec_types_pkg.sv
// Shared types for the BTC component decoder datapath.
//   strb_t : per-sample framing strobes (start/end of frame, start/end of line).
//            Field order is fixed, so a 4-bit literal {sof,sop,eop,eof} maps directly onto it.
package btc_dec_types;

    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

endpackage

// File: rtl/btc_dec_comp_code_deser.sv
// Row-mode deserializer for one component decoder.
// It packs pDEC_NUM serial samples into one line and parks the finished line
// in a hold register until the output arbiter grants it.
// Ports:
//   iclk, ireset (async, active-low), iclkena : clock, reset, clock enable
//   iclear      : drop all in-flight state (used for col mode and on mode change)
//   ival/istrb/ihd/iLextr : one serial sample
//   igrant      : arbiter takes the hold register this cycle
//   opend       : hold register contains a line that has not been emitted yet
//   ohold_*     : held line (hard decisions, extrinsics, fill mask, OR of strobes)
//   ocoll       : a new line overwrites a pending line that is not being emitted
module btc_dec_comp_code_deser
    import btc_dec_types::*;
#(
    parameter int pEXTR_W  = 5,
    parameter int pDEC_NUM = 8
) (
    input  logic                       iclk,
    input  logic                       ireset,
    input  logic                       iclkena,
    input  logic                       iclear,
    input  logic                       ival,
    input  strb_t                      istrb,
    input  logic                       ihd,
    input  logic signed [pEXTR_W-1:0]  iLextr,
    input  logic                       igrant,
    output logic                       opend,
    output logic [pDEC_NUM-1:0]        ohold_hd,
    output logic signed [pEXTR_W-1:0]  ohold_Lextr [pDEC_NUM],
    output logic [pDEC_NUM-1:0]        ohold_fill,
    output strb_t                      ohold_strb,
    output logic                       ocoll
);

    localparam int cCNT_W = $clog2(pDEC_NUM);

    logic [cCNT_W-1:0]          cnt;
    logic [pDEC_NUM-1:0]        line_hd;
    logic signed [pEXTR_W-1:0]  line_lextr [pDEC_NUM];
    logic [pDEC_NUM-1:0]        fill;
    strb_t                      acc;

    logic                       wr;
    logic                       last;
    logic [cCNT_W-1:0]          slot;
    logic [pDEC_NUM-1:0]        hd_n;
    logic signed [pEXTR_W-1:0]  lextr_n [pDEC_NUM];
    logic [pDEC_NUM-1:0]        fill_n;
    strb_t                      acc_n;

    // Next line contents including the current sample. A sop restarts the
    // line, so anything collected before it is discarded.
    always_comb begin
        wr     = ival & ~iclear;
        slot   = istrb.sop ? '0 : cnt;
        last   = wr & ((slot == cCNT_W'(pDEC_NUM - 1)) | istrb.eop);
        hd_n   = istrb.sop ? '0 : line_hd;
        fill_n = istrb.sop ? '0 : fill;
        acc_n  = istrb.sop ? '0 : acc;
        for (int i = 0; i < pDEC_NUM; i++) begin
            lextr_n[i] = istrb.sop ? '0 : line_lextr[i];
        end
        hd_n[slot]    = ihd;
        lextr_n[slot] = iLextr;
        fill_n[slot]  = 1'b1;
        acc_n         = acc_n | istrb;
        ocoll         = last & opend & ~igrant;
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            cnt        <= '0;
            line_hd    <= '0;
            fill       <= '0;
            acc        <= '0;
            opend      <= 1'b0;
            ohold_hd   <= '0;
            ohold_fill <= '0;
            ohold_strb <= '0;
            for (int i = 0; i < pDEC_NUM; i++) begin
                line_lextr[i]  <= '0;
                ohold_Lextr[i] <= '0;
            end
        end else if (iclkena) begin
            if (iclear) begin
                cnt   <= '0;
                fill  <= '0;
                acc   <= '0;
                opend <= 1'b0;
            end else if (last) begin
                // Unfilled slots are masked so stale buffer data never leaves.
                ohold_hd   <= hd_n & fill_n;
                ohold_fill <= fill_n;
                ohold_strb <= acc_n;
                for (int i = 0; i < pDEC_NUM; i++) begin
                    ohold_Lextr[i] <= fill_n[i] ? lextr_n[i] : '0;
                end
                opend <= 1'b1;
                cnt   <= '0;
                fill  <= '0;
                acc   <= '0;
            end else begin
                if (igrant) begin
                    opend <= 1'b0;
                end
                if (wr) begin
                    line_hd    <= hd_n;
                    line_lextr <= lextr_n;
                    fill       <= fill_n;
                    acc        <= acc_n;
                    cnt        <= slot + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/btc_dec_comp_code_sink.sv
// Output side of the component decoders: turns per-decoder hard decisions
// and extrinsics back into line words for the extrinsic/HD memory writer.
//   col mode : registered pass-through of the co-indexed decoder outputs
//   row mode : one deserializer per decoder plus a lowest-index-first arbiter
//              that emits at most one line per cycle
// Ports:
//   iclk, ireset (async, active-low), iclkena, irow_mode
//   ival/istrb/ihd/iLextr : per-decoder samples
//   oval/ovec/ostrb/ohd/oLextr : line word, its slot-valid mask and strobes
//   oerr : sticky, set when a pending line is overwritten before emission
module btc_dec_comp_code_sink
    import btc_dec_types::*;
#(
    parameter int pEXTR_W  = 5,
    parameter int pDEC_NUM = 8
) (
    input  logic                       iclk,
    input  logic                       ireset,
    input  logic                       iclkena,
    input  logic                       irow_mode,
    input  logic [pDEC_NUM-1:0]        ival,
    input  strb_t [pDEC_NUM-1:0]       istrb,
    input  logic [pDEC_NUM-1:0]        ihd,
    input  logic signed [pEXTR_W-1:0]  iLextr [pDEC_NUM],
    output logic                       oval,
    output logic [pDEC_NUM-1:0]        ovec,
    output strb_t                      ostrb,
    output logic [pDEC_NUM-1:0]        ohd,
    output logic signed [pEXTR_W-1:0]  oLextr [pDEC_NUM],
    output logic                       oerr
);

    localparam int cIDX_W = $clog2(pDEC_NUM);

    logic                       mode_r;
    logic                       mode_chg;
    logic                       row_act;
    logic [pDEC_NUM-1:0]        pend;
    logic [pDEC_NUM-1:0]        grant;
    logic [pDEC_NUM-1:0]        coll;
    logic [cIDX_W-1:0]          gsel;
    logic                       gany;
    strb_t                      col_strb;
    logic [pDEC_NUM-1:0]        hold_hd    [pDEC_NUM];
    logic signed [pEXTR_W-1:0]  hold_lextr [pDEC_NUM][pDEC_NUM];
    logic [pDEC_NUM-1:0]        hold_fill  [pDEC_NUM];
    strb_t                      hold_strb  [pDEC_NUM];

    // A mode flip flushes every deserializer on the same edge it is seen.
    assign mode_chg = irow_mode ^ mode_r;
    assign row_act  = irow_mode & ~mode_chg;

    // Priority pick: scanning downwards leaves the lowest pending index.
    always_comb begin
        gsel  = '0;
        gany  = 1'b0;
        grant = '0;
        for (int g = pDEC_NUM - 1; g >= 0; g--) begin
            if (pend[g]) begin
                gsel = cIDX_W'(g);
                gany = 1'b1;
            end
        end
        if (row_act && gany) begin
            grant[gsel] = 1'b1;
        end
    end

    always_comb begin
        col_strb = '0;
        for (int g = pDEC_NUM - 1; g >= 0; g--) begin
            if (ival[g]) begin
                col_strb = istrb[g];
            end
        end
    end

    for (genvar g = 0; g < pDEC_NUM; g++) begin : g_deser
        btc_dec_comp_code_deser #(
            .pEXTR_W  (pEXTR_W),
            .pDEC_NUM (pDEC_NUM)
        ) u_deser (
            .iclk        (iclk),
            .ireset      (ireset),
            .iclkena     (iclkena),
            .iclear      (~row_act),
            .ival        (ival[g]),
            .istrb       (istrb[g]),
            .ihd         (ihd[g]),
            .iLextr      (iLextr[g]),
            .igrant      (grant[g]),
            .opend       (pend[g]),
            .ohold_hd    (hold_hd[g]),
            .ohold_Lextr (hold_lextr[g]),
            .ohold_fill  (hold_fill[g]),
            .ohold_strb  (hold_strb[g]),
            .ocoll       (coll[g])
        );
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            mode_r <= 1'b0;
            oerr   <= 1'b0;
            oval   <= 1'b0;
            ovec   <= '0;
            ostrb  <= '0;
            ohd    <= '0;
            for (int i = 0; i < pDEC_NUM; i++) begin
                oLextr[i] <= '0;
            end
        end else if (iclkena) begin
            mode_r <= irow_mode;
            if (|coll) begin
                oerr <= 1'b1;
            end
            if (!irow_mode) begin
                oval  <= |ival;
                ovec  <= ival;
                ostrb <= col_strb;
                ohd   <= ival & ihd;
                for (int i = 0; i < pDEC_NUM; i++) begin
                    oLextr[i] <= ival[i] ? iLextr[i] : '0;
                end
            end else if (row_act && gany) begin
                oval   <= 1'b1;
                ovec   <= hold_fill[gsel];
                ostrb  <= hold_strb[gsel];
                ohd    <= hold_hd[gsel];
                oLextr <= hold_lextr[gsel];
            end else begin
                oval  <= 1'b0;
                ovec  <= '0;
                ostrb <= '0;
                ohd   <= '0;
                for (int i = 0; i < pDEC_NUM; i++) begin
                    oLextr[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_btc_dec_comp_code_sink.sv
// Directed bench for btc_dec_comp_code_sink with 4 decoders, 5-bit extrinsics.
// Slot i of a vector literal {a,b,c,d} is written out per index below (slot 0 = d).
module tb_btc_dec_comp_code_sink;
    import btc_dec_types::*;

    localparam int N = 4;
    localparam int W = 5;
    localparam strb_t S0   = 4'b0000;
    localparam strb_t SOF  = 4'b1000;
    localparam strb_t SOP  = 4'b0100;
    localparam strb_t EOP  = 4'b0010;
    localparam strb_t EOF  = 4'b0001;
    localparam strb_t SPEP = 4'b0110;

    logic                 iclk = 1'b0;
    logic                 ireset;
    logic                 iclkena;
    logic                 irow_mode;
    logic [N-1:0]         ival;
    strb_t [N-1:0]        istrb;
    logic [N-1:0]         ihd;
    logic signed [W-1:0]  iLextr [N];
    logic                 oval;
    logic [N-1:0]         ovec;
    strb_t                ostrb;
    logic [N-1:0]         ohd;
    logic signed [W-1:0]  oLextr [N];
    logic                 oerr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 iclk = ~iclk;

    btc_dec_comp_code_sink #(.pEXTR_W(W), .pDEC_NUM(N)) dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .iclkena   (iclkena),
        .irow_mode (irow_mode),
        .ival      (ival),
        .istrb     (istrb),
        .ihd       (ihd),
        .iLextr    (iLextr),
        .oval      (oval),
        .ovec      (ovec),
        .ostrb     (ostrb),
        .ohd       (ohd),
        .oLextr    (oLextr),
        .oerr      (oerr)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic clear_in();
        ival  = '0;
        istrb = '0;
        ihd   = '0;
        for (int i = 0; i < N; i++) iLextr[i] = '0;
    endtask

    task automatic smp(input int g, input int l, input logic h, input strb_t s);
        ival[g]   = 1'b1;
        iLextr[g] = W'(l);
        ihd[g]    = h;
        istrb[g]  = s;
    endtask

    task automatic chk_line(input string tag, input int v, input int hd, input int s,
                            input int l0, input int l1, input int l2, input int l3);
        chk({tag, "_oval"}, int'(oval), 1);
        chk({tag, "_ovec"}, int'(ovec), v);
        chk({tag, "_ohd"}, int'(ohd), hd);
        chk({tag, "_ostrb"}, int'(ostrb), s);
        chk({tag, "_l0"}, int'(oLextr[0]), l0);
        chk({tag, "_l1"}, int'(oLextr[1]), l1);
        chk({tag, "_l2"}, int'(oLextr[2]), l2);
        chk({tag, "_l3"}, int'(oLextr[3]), l3);
    endtask

    initial begin
        ireset    = 1'b0;
        iclkena   = 1'b1;
        irow_mode = 1'b0;
        clear_in();
        repeat (2) tick();
        chk("rst_oval", int'(oval), 0);
        chk("rst_ovec", int'(ovec), 0);
        chk("rst_ostrb", int'(ostrb), 0);
        chk("rst_oerr", int'(oerr), 0);
        ireset = 1'b1;
        tick();

        // Col mode: slot 2 not valid -> zeroed, strobe from slot 0
        smp(0, 15, 1'b1, SPEP);
        smp(1, 7, 1'b1, EOF);
        iLextr[2] = -5; ihd[2] = 1'b0; istrb[2] = SOF;
        smp(3, 3, 1'b1, EOF);
        tick();
        chk_line("t1", 4'b1011, 4'b1011, 4'b0110, 15, 7, 0, 3);
        // Col mode: lowest valid is slot 1, invalid hd bits masked
        ival = 4'b1010; ihd = 4'b1111;
        tick();
        chk_line("t1b", 4'b1010, 4'b1010, 4'b0001, 0, 7, 0, 3);
        clear_in();
        tick();
        chk("t1c_oval", int'(oval), 0);

        // Switch to row mode (one flush cycle)
        irow_mode = 1'b1;
        tick();
        chk("mode_oval", int'(oval), 0);

        // Row mode, decoder 1, full line with sop on first sample
        for (int k = 0; k < 4; k++) begin
            clear_in();
            smp(1, k + 1, (k == 0 || k == 3), (k == 0) ? SOP : S0);
            tick();
            chk($sformatf("t2_idle%0d", k), int'(oval), 0);
        end
        clear_in();
        tick();
        chk_line("t2", 4'b1111, 4'b1001, 4'b0100, 1, 2, 3, 4);
        tick();
        chk("t2_after", int'(oval), 0);

        // Row mode, decoders 0 and 2 complete together
        for (int k = 0; k < 4; k++) begin
            clear_in();
            smp(0, 5 + k, 1'b1, (k == 0) ? SOP : S0);
            smp(2, -1 - k, 1'b0, (k == 0) ? SOP : S0);
            tick();
        end
        clear_in();
        tick();
        chk_line("t3a", 4'b1111, 4'b1111, 4'b0100, 5, 6, 7, 8);
        tick();
        chk_line("t3b", 4'b1111, 4'b0000, 4'b0100, -1, -2, -3, -4);
        chk("t3_oerr", int'(oerr), 0);
        tick();
        chk("t3_after", int'(oval), 0);

        // Decoder 3 overwritten while decoder 0 keeps winning arbitration
        clear_in(); smp(0, 1, 1'b1, SPEP); smp(3, 9, 1'b1, SPEP);
        tick();
        chk("t4_c0_oval", int'(oval), 0);
        clear_in(); smp(0, 2, 1'b1, SPEP);
        tick();
        chk("t4_c1_l0", int'(oLextr[0]), 1);
        chk("t4_c1_oerr", int'(oerr), 0);
        clear_in(); smp(0, 3, 1'b1, SPEP); smp(3, -9, 1'b0, SPEP);
        tick();
        chk("t4_c2_l0", int'(oLextr[0]), 2);
        chk("t4_c2_oerr", int'(oerr), 1);
        clear_in();
        tick();
        chk("t4_c3_l0", int'(oLextr[0]), 3);
        tick();
        chk_line("t4_d3", 4'b0001, 4'b0000, 4'b0110, -9, 0, 0, 0);
        tick();
        chk("t4_after", int'(oval), 0);

        // Short line: sop then eop on second sample
        clear_in(); smp(2, -7, 1'b1, SOP);
        tick();
        clear_in(); smp(2, 6, 1'b0, EOP);
        tick();
        chk("t5_idle", int'(oval), 0);
        clear_in();
        tick();
        chk_line("t5", 4'b0011, 4'b0001, 4'b0110, -7, 6, 0, 0);

        // Reset in the middle of a line
        clear_in(); smp(1, 10, 1'b1, SOP);
        tick();
        smp(1, 11, 1'b1, S0);
        tick();
        #2 ireset = 1'b0;
        #1;
        chk("t6_rst_oval", int'(oval), 0);
        chk("t6_rst_oerr", int'(oerr), 0);
        chk("t6_rst_ovec", int'(ovec), 0);
        tick();
        chk("t6_rst_l0", int'(oLextr[0]), 0);
        clear_in();
        ireset = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            clear_in();
            smp(1, (k == 0) ? 1 : (k == 1) ? -1 : (k == 2) ? 2 : -2, (k == 1 || k == 2), S0);
            tick();
        end
        clear_in();
        tick();
        chk_line("t6", 4'b1111, 4'b0110, 4'b0000, 1, -1, 2, -2);
        chk("t6_oerr", int'(oerr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
